multicycle_ctrl: RTL and testbench

- Main control FSM for the multi-cycle RV32I datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives every datapath mux select, write enable and memory handshake.
- Takes the opcode from the instruction register (the same field the immediate generator decodes) and flags illegal opcodes and memory timeouts.

---
 rtl/riscv_pkg.sv | 61 ++++++
 rtl/multicycle_ctrl_if.sv | 20 ++
 rtl/multicycle_ctrl_timer.sv | 31 +++
 rtl/multicycle_ctrl.sv | 147 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I control definitions: opcodes (also used by the immediate decoder),
// controller state encoding and datapath mux select encodings.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_ALUOUT = 2'd1,
    PC_JALR   = 2'd2
  } pc_sel_t;

  typedef enum logic [1:0] {
    A_RS1  = 2'd0,
    A_PC   = 2'd1,
    A_ZERO = 2'd2
  } alu_a_t;

  typedef enum logic {
    B_RS2 = 1'b0,
    B_IMM = 1'b1
  } alu_b_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_FUNCT = 2'd1,
    ALU_CMP   = 2'd2
  } alu_op_t;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2
  } wb_sel_t;

  function automatic logic is_legal_opcode(input logic [6:0] op);
    case (op)
      OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction and data memory handshake between the controller and memory.
// A request (imem_req/dmem_req) stays high until its ready arrives; the transfer
// completes in the cycle where req and ready are both 1, and ready without req is ignored.
interface multicycle_ctrl_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;

  modport master (
    output imem_req, dmem_req, dmem_we,
    input  imem_ready, dmem_ready
  );

  modport slave (
    input  imem_req, dmem_req, dmem_we,
    output imem_ready, dmem_ready
  );
endinterface

// File: rtl/multicycle_ctrl_timer.sv
// Memory-wait counter: counts cycles a request stays unacknowledged and flags
// the last allowed cycle; TIMEOUT of 0 never expires.
module handshake_timer #(
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT - 1);

  logic [TIMEOUT_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + TIMEOUT_W'(1);
    end
  end

  // Expiry is only meaningful in a waiting cycle; the caller qualifies it with ready.
  assign expired = (TIMEOUT != 0) && (count == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I datapath: sequences
// fetch/decode/execute/memory/writeback and drives all mux selects and enables.
module multicycle_ctrl
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 200
) (
  input  logic                clk,
  input  logic                rst,
  multicycle_ctrl_if.master   mem,
  input  logic [6:0]          opcode,
  input  logic                branch_taken,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_sel,
  output logic [1:0]          alu_src_a,
  output logic                alu_src_b,
  output logic [1:0]          alu_op,
  output logic                reg_write,
  output logic [1:0]          wb_sel,
  output logic                instret,
  output logic                fault,
  output logic [2:0]          state_dbg
);

  state_t state, state_n;
  logic   waiting;
  logic   expired;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= state_n;
  end

  assign waiting = rst && (((state == S_FETCH) && !mem.imem_ready) ||
                           ((state == S_MEM)   && !mem.dmem_ready));

  handshake_timer #(
    .TIMEOUT_W (TIMEOUT_W),
    .TIMEOUT   (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!waiting),
    .en      (waiting),
    .expired (expired)
  );

  // Everything is gated by rst so requests and enables drop as soon as reset asserts.
  always_comb begin
    state_n      = state;
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    mem.dmem_we  = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_sel       = PC_PLUS4;
    alu_src_a    = A_RS1;
    alu_src_b    = B_RS2;
    alu_op       = ALU_ADD;
    reg_write    = 1'b0;
    wb_sel       = WB_ALU;
    instret      = 1'b0;
    if (rst) begin
      case (state)
        S_FETCH: begin
          mem.imem_req = 1'b1;
          if (mem.imem_ready) begin
            ir_write = 1'b1;
            state_n  = S_DECODE;
          end else if (expired) begin
            state_n = S_TRAP;
          end
        end
        S_DECODE: begin
          // Branch target PC+imm is formed here so EXEC is free for the compare.
          alu_src_a = A_PC;
          alu_src_b = B_IMM;
          state_n   = is_legal_opcode(opcode) ? S_EXEC : S_TRAP;
        end
        S_EXEC: begin
          state_n = S_WB;
          case (opcode)
            OP_R: alu_op = ALU_FUNCT;
            OP_IMM: begin
              alu_src_b = B_IMM;
              alu_op    = ALU_FUNCT;
            end
            OP_LOAD, OP_STORE: begin
              alu_src_b = B_IMM;
              state_n   = S_MEM;
            end
            OP_JALR: alu_src_b = B_IMM;
            OP_LUI: begin
              alu_src_a = A_ZERO;
              alu_src_b = B_IMM;
            end
            OP_AUIPC, OP_JAL: begin
              alu_src_a = A_PC;
              alu_src_b = B_IMM;
            end
            OP_BRANCH: begin
              alu_op   = ALU_CMP;
              pc_write = 1'b1;
              pc_sel   = branch_taken ? PC_ALUOUT : PC_PLUS4;
              instret  = 1'b1;
              state_n  = S_FETCH;
            end
            default: state_n = S_TRAP;
          endcase
        end
        S_MEM: begin
          mem.dmem_req = 1'b1;
          mem.dmem_we  = (opcode == OP_STORE);
          if (mem.dmem_ready) begin
            if (opcode == OP_STORE) begin
              pc_write = 1'b1;
              instret  = 1'b1;
              state_n  = S_FETCH;
            end else begin
              state_n = S_WB;
            end
          end else if (expired) begin
            state_n = S_TRAP;
          end
        end
        S_WB: begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
          instret   = 1'b1;
          state_n   = S_FETCH;
          if (opcode == OP_LOAD)                             wb_sel = WB_LOAD;
          else if ((opcode == OP_JAL) || (opcode == OP_JALR)) wb_sel = WB_PC4;
          if (opcode == OP_JAL)       pc_sel = PC_ALUOUT;
          else if (opcode == OP_JALR) pc_sel = PC_JALR;
        end
        S_TRAP:  state_n = S_TRAP;
        default: state_n = S_TRAP;
      endcase
    end
  end

  assign fault     = rst && (state == S_TRAP);
  assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-cycle expected control vectors are queued per
// scenario and compared against the sampled outputs cycle by cycle.
module tb_multicycle_ctrl;

  localparam int VW = 15;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] opcode = '0;
  logic       branch_taken = 1'b0;
  logic       ir_write, pc_write, alu_src_b, reg_write, instret, fault;
  logic [1:0] pc_sel, alu_src_a, alu_op, wb_sel;
  logic [2:0] state_dbg;

  multicycle_ctrl_if mif ();

  multicycle_ctrl #(.TIMEOUT_W(8), .TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem          (mif.master),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_sel       (pc_sel),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .reg_write    (reg_write),
    .wb_sel       (wb_sel),
    .instret      (instret),
    .fault        (fault),
    .state_dbg    (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] obs, exp_v;
  logic [4:0]    obs_alu;
  int            checks = 0;
  int            passed = 0;

  // Expected vector: {state, imem_req, ir_write, dmem_req, dmem_we, pc_write,
  // pc_sel, reg_write, wb_sel, instret, fault}; selects zeroed when their enable is low.
  function automatic logic [VW-1:0] mk(input int st, input int ireq, input int irw,
                                       input int dreq, input int dwe, input int pcw,
                                       input int psel, input int rw, input int wsel,
                                       input int ret, input int flt);
    return {3'(st), 1'(ireq), 1'(irw), 1'(dreq), (dreq != 0) ? 1'(dwe) : 1'b0,
            1'(pcw), (pcw != 0) ? 2'(psel) : 2'b0, 1'(rw),
            (rw != 0) ? 2'(wsel) : 2'b0, 1'(ret), 1'(flt)};
  endfunction

  // Driver: apply inputs just after a rising edge, sample at the falling edge.
  task automatic step(input int ir, input int dr, input int tk);
    mif.imem_ready = 1'(ir);
    mif.dmem_ready = 1'(dr);
    branch_taken   = 1'(tk);
    @(negedge clk);
    obs = {state_dbg, mif.imem_req, ir_write, mif.dmem_req,
           mif.dmem_req ? mif.dmem_we : 1'b0, pc_write, pc_write ? pc_sel : 2'b0,
           reg_write, reg_write ? wb_sel : 2'b0, instret, fault};
    obs_alu = {alu_src_a, alu_src_b, alu_op};
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    opcode = OP_R;
    mif.imem_ready = 1'b1;
    mif.dmem_ready = 1'b1;
    branch_taken = 1'b1;
    @(negedge clk);
    checks++;
    if ({mif.imem_req, mif.dmem_req, mif.dmem_we, ir_write, pc_write, pc_sel, alu_src_a,
         alu_src_b, alu_op, reg_write, wb_sel, instret, fault, state_dbg} !== '0)
      $display("FAIL reset_outputs: got imem_req=%b dmem_req=%b ir_write=%b state=%0d fault=%b, want all 0",
               mif.imem_req, mif.dmem_req, ir_write, state_dbg, fault);
    else passed++;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_rtype();
    opcode = OP_R;
    exp_q.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(4, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0));
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0);
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) $display("FAIL rtype cyc %0d: got %h want %h", i, obs, exp_v);
      else passed++;
      if (i == 2) begin
        checks++;
        if (obs_alu !== 5'b00001) $display("FAIL rtype_alu: got %b want 00001", obs_alu);
        else passed++;
      end
    end
  endtask

  task automatic test_load_wait();
    opcode = OP_LOAD;
    exp_q.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(4, 0, 0, 0, 0, 1, 0, 1, 1, 1, 0));
    for (int i = 0; i < 8; i++) begin
      step(1, (i == 6) ? 1 : 0, 0);
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) $display("FAIL load_wait cyc %0d: got %h want %h", i, obs, exp_v);
      else passed++;
    end
  endtask

  task automatic test_branch();
    opcode = OP_BRANCH;
    for (int t = 1; t >= 0; t--) begin
      exp_q.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      exp_q.push_back(mk(2, 0, 0, 0, 0, 1, t, 0, 0, 1, 0));
      for (int i = 0; i < 3; i++) begin
        step(1, 1, t);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) $display("FAIL branch taken=%0d cyc %0d: got %h want %h", t, i, obs, exp_v);
        else passed++;
        if (i == 1) begin
          checks++;
          if (obs_alu[4:2] !== 3'b011) $display("FAIL branch_target_src: got %b want 011", obs_alu[4:2]);
          else passed++;
        end
        if (i == 2) begin
          checks++;
          if (obs_alu[1:0] !== 2'd2) $display("FAIL branch_alu_op: got %0d want 2", obs_alu[1:0]);
          else passed++;
        end
      end
    end
  endtask

  task automatic test_jalr();
    opcode = OP_JALR;
    exp_q.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(4, 0, 0, 0, 0, 1, 2, 1, 2, 1, 0));
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0);
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) $display("FAIL jalr cyc %0d: got %h want %h", i, obs, exp_v);
      else passed++;
      if (i == 2) begin
        checks++;
        if (obs_alu !== 5'b00100) $display("FAIL jalr_alu: got %b want 00100", obs_alu);
        else passed++;
      end
    end
  endtask

  task automatic test_others();
    logic [6:0] ops [5];
    logic [4:0] alu_exp [5];
    logic [4:0] alu_msk [5];
    ops     = '{OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_STORE};
    alu_exp = '{5'b00101, 5'b10100, 5'b01100, 5'b01100, 5'b00100};
    alu_msk = '{5'b11111, 5'b11100, 5'b11100, 5'b11100, 5'b11111};
    for (int k = 0; k < 5; k++) begin
      opcode = ops[k];
      exp_q.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      exp_q.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      if (ops[k] == OP_STORE)    exp_q.push_back(mk(3, 0, 0, 1, 1, 1, 0, 0, 0, 1, 0));
      else if (ops[k] == OP_JAL) exp_q.push_back(mk(4, 0, 0, 0, 0, 1, 1, 1, 2, 1, 0));
      else                       exp_q.push_back(mk(4, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0));
      for (int i = 0; i < 4; i++) begin
        step(1, 1, 0);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) $display("FAIL op %b cyc %0d: got %h want %h", ops[k], i, obs, exp_v);
        else passed++;
        if (i == 2) begin
          checks++;
          if ((obs_alu & alu_msk[k]) !== alu_exp[k])
            $display("FAIL op %b exec_alu: got %b want %b", ops[k], obs_alu & alu_msk[k], alu_exp[k]);
          else passed++;
        end
      end
    end
  endtask

  task automatic test_illegal();
    opcode = 7'b0000000;
    exp_q.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 1);
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) $display("FAIL illegal cyc %0d: got %h want %h", i, obs, exp_v);
      else passed++;
    end
    opcode = OP_R;
    apply_reset();
    exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(0, 0, 0);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v) $display("FAIL illegal_after_reset: got %h want %h", obs, exp_v);
    else passed++;
  endtask

  task automatic test_timeout();
    opcode = OP_R;
    apply_reset();
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 2; i++) exp_q.push_back(mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0);
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) $display("FAIL timeout cyc %0d: got %h want %h", i, obs, exp_v);
      else passed++;
    end
    apply_reset();
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(4, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0));
    for (int i = 0; i < 7; i++) begin
      step((i == 3) ? 1 : 0, 0, 0);
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) $display("FAIL timeout_edge cyc %0d: got %h want %h", i, obs, exp_v);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    opcode = OP_STORE;
    exp_q.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(3, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0);
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) $display("FAIL reset_mid cyc %0d: got %h want %h", i, obs, exp_v);
      else passed++;
    end
    mif.dmem_ready = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({mif.dmem_req, pc_write, instret, reg_write, state_dbg} !== 7'b0)
      $display("FAIL reset_mid_drop: got dmem_req=%b pc_write=%b instret=%b state=%0d want 0",
               mif.dmem_req, pc_write, instret, state_dbg);
    else passed++;
    @(posedge clk);
    #1;
    rst = 1'b1;
    opcode = OP_R;
    exp_q.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    step(1, 0, 0);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v) $display("FAIL reset_mid_restart: got %h want %h", obs, exp_v);
    else passed++;
  endtask

  initial begin
    mif.imem_ready = 1'b0;
    mif.dmem_ready = 1'b0;
    test_reset();
    test_rtype();
    test_load_wait();
    test_branch();
    test_jalr();
    test_others();
    test_illegal();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
